// File: rtl/easyaxi_mst_rd_gen.sv
// easyaxi_mst_rd_gen: AXI read-traffic generator master.
// Issues a programmed run of single-beat AR requests (base + n*stride, incrementing ID)
// with at most MAX_OST in flight, retires R responses and pulses done.
// Optional macro EASYAXI_MST_RD_ERRCNT_EN adds err_cnt, a saturating count of non-OKAY R beats.
module easyaxi_mst_rd_gen #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MAX_OST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [ADDR_W-1:0]              cfg_base_addr,
  input  logic [ADDR_W-1:0]              cfg_stride,
  input  logic [CNT_W-1:0]               cfg_num_txn,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_OST+1)-1:0]   ost_cnt,
  output logic                           axi_mst_arvalid,
  input  logic                           axi_mst_arready,
  output logic [ID_W-1:0]                axi_mst_arid,
  output logic [ADDR_W-1:0]              axi_mst_araddr,
  input  logic                           axi_mst_rvalid,
  output logic                           axi_mst_rready,
  input  logic [ID_W-1:0]                axi_mst_rid,
  input  logic [1:0]                     axi_mst_rresp,
  input  logic                           axi_mst_rlast
`ifdef EASYAXI_MST_RD_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]               err_cnt
`endif
);

  localparam int unsigned OST_W = $clog2(MAX_OST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_nx;
  logic                arvalid_nx, rready_nx, busy_nx, done_nx;
  logic [ID_W-1:0]     arid_nx;
  logic [ADDR_W-1:0]   araddr_nx, stride_q, stride_nx;
  logic [CNT_W-1:0]    idx_q, idx_nx, num_q, num_nx;
  logic [OST_W-1:0]    ost_nx;
  logic                ar_hs, retire, start;

  // R ID is informational only; responses are retired purely by rlast
  logic unused;
`ifdef EASYAXI_MST_RD_ERRCNT_EN
  assign unused = ^axi_mst_rid;
`else
  assign unused = ^{axi_mst_rid, axi_mst_rresp};
`endif

  // Next-state, AR sequencing and outstanding-count bookkeeping
  always_comb begin
    state_nx   = state;
    arvalid_nx = axi_mst_arvalid;
    arid_nx    = axi_mst_arid;
    araddr_nx  = axi_mst_araddr;
    idx_nx     = idx_q;
    stride_nx  = stride_q;
    num_nx     = num_q;
    start      = 1'b0;
    ar_hs      = axi_mst_arvalid & axi_mst_arready;
    retire     = axi_mst_rvalid & axi_mst_rready & axi_mst_rlast & (ost_cnt != '0);
    ost_nx     = ost_cnt + OST_W'(ar_hs) - OST_W'(retire);

    case (state)
      IDLE: begin
        if (enable) begin
          start     = 1'b1;
          stride_nx = cfg_stride;
          num_nx    = cfg_num_txn;
          idx_nx    = '0;
          arid_nx   = '0;
          araddr_nx = cfg_base_addr;
          if (cfg_num_txn != '0) begin
            state_nx   = ISSUE;
            arvalid_nx = 1'b1;
          end else begin
            state_nx   = DONE;
          end
        end
      end
      ISSUE: begin
        if (ar_hs) begin
          idx_nx    = idx_q + CNT_W'(1);
          arid_nx   = axi_mst_arid + ID_W'(1);
          araddr_nx = axi_mst_araddr + stride_q;
        end
        if (ar_hs && (idx_nx == num_q)) begin
          state_nx   = DRAIN;
          arvalid_nx = 1'b0;
        end else if (!axi_mst_arvalid || ar_hs) begin
          // A pending AR is never retracted; only re-evaluate once it is free
          arvalid_nx = (ost_nx < OST_W'(MAX_OST));
        end
      end
      DRAIN: begin
        if (ost_cnt == '0) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx   = IDLE;
        arvalid_nx = 1'b0;
      end
    endcase

    busy_nx   = (state_nx == ISSUE) || (state_nx == DRAIN);
    rready_nx = busy_nx;
    done_nx   = (state_nx == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      axi_mst_arvalid <= 1'b0;
      axi_mst_arid    <= '0;
      axi_mst_araddr  <= '0;
      axi_mst_rready  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ost_cnt         <= '0;
      idx_q           <= '0;
      stride_q        <= '0;
      num_q           <= '0;
    end else begin
      state           <= state_nx;
      axi_mst_arvalid <= arvalid_nx;
      axi_mst_arid    <= arid_nx;
      axi_mst_araddr  <= araddr_nx;
      axi_mst_rready  <= rready_nx;
      busy            <= busy_nx;
      done            <= done_nx;
      ost_cnt         <= ost_nx;
      idx_q           <= idx_nx;
      stride_q        <= stride_nx;
      num_q           <= num_nx;
    end
  end

`ifdef EASYAXI_MST_RD_ERRCNT_EN
  logic [CNT_W-1:0] err_nx;

  // Saturating count of non-OKAY R beats, cleared at each start
  always_comb begin
    err_nx = err_cnt;
    if (start) begin
      err_nx = '0;
    end else if (axi_mst_rvalid && axi_mst_rready && (axi_mst_rresp != 2'b00) &&
                 (err_cnt != {CNT_W{1'b1}})) begin
      err_nx = err_cnt + CNT_W'(1);
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt <= '0;
    else        err_cnt <= err_nx;
  end
`endif

endmodule

// File: tb/tb_easyaxi_mst_rd_gen.sv
// tb_easyaxi_mst_rd_gen: scoreboard bench for the AXI read-traffic generator.
// Expected ARs are queued at start and popped on each AR handshake; a delayed R responder
// retires them. Define EASYAXI_MST_RD_ERRCNT_EN to also exercise err_cnt.
module tb_easyaxi_mst_rd_gen;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MAX_OST = 4;
  localparam int unsigned OST_W   = $clog2(MAX_OST + 1);

  logic              clk, rst_n, enable;
  logic [ADDR_W-1:0] cfg_base_addr, cfg_stride;
  logic [CNT_W-1:0]  cfg_num_txn;
  logic              busy, done;
  logic [OST_W-1:0]  ost_cnt;
  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready, rlast;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
`ifdef EASYAXI_MST_RD_ERRCNT_EN
  logic [CNT_W-1:0]  err_cnt;
`endif

  easyaxi_mst_rd_gen #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .CNT_W(CNT_W), .MAX_OST(MAX_OST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride), .cfg_num_txn(cfg_num_txn),
    .busy(busy), .done(done), .ost_cnt(ost_cnt),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready),
    .axi_mst_arid(arid), .axi_mst_araddr(araddr),
    .axi_mst_rvalid(rvalid), .axi_mst_rready(rready),
    .axi_mst_rid(rid), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast)
`ifdef EASYAXI_MST_RD_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [ID_W-1:0]   exp_id[$];
  int r_pend[$];
  int r_delay   = 2;
  int r_allow   = 1000000;
  int err_left  = 0;
  int done_cnt  = 0;
  int done_base = 0;
  int ar_hs_cnt = 0;
  int av_cnt    = 0;
  int sim_cnt   = 0;
  int ost_m     = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare, count, and report one observation
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // R responder: one beat per cycle once a pending response is due
  always @(posedge clk) begin
    #1;
    if (r_pend.size() > 0 && r_pend[0] <= cyc && r_allow > 0) begin
      rvalid = 1'b1;
      rlast  = 1'b1;
      rid    = '0;
      rresp  = (err_left > 0) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rid    = '0;
      rresp  = 2'b00;
    end
  end

  // Monitor: AR scoreboard, outstanding-count model, done pulse checks
  always @(negedge clk) begin : mon
    logic hs, ret;
    check_eq("ost_cnt", 32'(ost_cnt), ost_m);
    hs  = arvalid & arready & rst_n;
    ret = rvalid & rready & rlast & rst_n & (ost_m != 0);
    if (arvalid) av_cnt++;
    if (hs) begin
      ar_hs_cnt++;
      if (exp_addr.size() == 0) begin
        check_eq("ar_unexpected", 32'(araddr), 32'hFFFF_FFFF);
      end else begin
        check_eq("araddr", 32'(araddr), 32'(exp_addr.pop_front()));
        check_eq("arid",   32'(arid),   32'(exp_id.pop_front()));
      end
      r_pend.push_back(cyc + 1 + r_delay);
    end
    if (rst_n && rvalid && rready) begin
      if (r_pend.size() > 0) void'(r_pend.pop_front());
      if (r_allow > 0) r_allow--;
      if (rresp != 2'b00 && err_left > 0) err_left--;
    end
    if (hs && ret) sim_cnt++;
    ost_m = !rst_n ? 0 : ost_m + int'(hs) - int'(ret);
    if (done) begin
      done_cnt++;
      check_eq("busy_at_done", 32'(busy), 0);
      check_eq("done_width", 32'(prev_done), 0);
    end
    prev_done = done;
  end

  task automatic start_run(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                           input int num);
    @(posedge clk); #1;
    cfg_base_addr = base;
    cfg_stride    = stride;
    cfg_num_txn   = CNT_W'(num);
    enable        = 1'b1;
    done_base     = done_cnt;
    for (int i = 0; i < num; i++) begin
      exp_addr.push_back(ADDR_W'(32'(base) + 32'(i) * 32'(stride)));
      exp_id.push_back(ID_W'(i));
    end
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && done_cnt == done_base; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check_eq({tag, "_done_cnt"}, 32'(done_cnt - done_base), 1);
    check_eq({tag, "_ar_left"}, 32'(exp_addr.size()), 0);
    check_eq({tag, "_ost_end"}, 32'(ost_cnt), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_arvalid"}, 32'(arvalid), 0);
    check_eq({tag, "_arid"},    32'(arid),    0);
    check_eq({tag, "_araddr"},  32'(araddr),  0);
    check_eq({tag, "_rready"},  32'(rready),  0);
    check_eq({tag, "_busy"},    32'(busy),    0);
    check_eq({tag, "_done"},    32'(done),    0);
    check_eq({tag, "_ost"},     32'(ost_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, av0;
    rst_n = 1'b0; enable = 1'b0; arready = 1'b1;
    cfg_base_addr = '0; cfg_stride = '0; cfg_num_txn = '0;
    rvalid = 1'b0; rlast = 1'b0; rid = '0; rresp = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic run with R two cycles after each AR
    r_delay = 2;
    start_run(16'h0100, 16'h0010, 3);
    wait_done("t1");

    // AR stalled by arready: payload must hold until the handshake
    arready = 1'b0;
    start_run(16'h2000, 16'h0004, 1);
    for (int i = 0; i < 20 && !arvalid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_arvalid_hold", 32'(arvalid), 1);
      check_eq("t2_arid_hold",    32'(arid),    0);
      check_eq("t2_araddr_hold",  32'(araddr),  32'h2000);
      @(negedge clk);
    end
    @(posedge clk); #1 arready = 1'b1;
    wait_done("t2");

    // Outstanding limit: no R -> exactly MAX_OST ARs, one retire frees one slot
    r_allow = 0;
    hs0 = ar_hs_cnt;
    start_run(16'h3000, 16'h0100, 8);
    repeat (20) @(negedge clk);
    check_eq("t3_ar_count", 32'(ar_hs_cnt - hs0), MAX_OST);
    check_eq("t3_arvalid_blocked", 32'(arvalid), 0);
    check_eq("t3_ost_full", 32'(ost_cnt), MAX_OST);
    r_allow = 1;
    for (int i = 0; i < 10 && !(rvalid && rready); i++) @(negedge clk);
    @(negedge clk);
    check_eq("t3_arvalid_after_retire", 32'(arvalid), 1);
    check_eq("t3_ost_after_retire", 32'(ost_cnt), MAX_OST - 1);
    r_allow = 1000000;
    wait_done("t3");

    // Address wrap, then ID wrap over 18 transactions
    start_run(16'hFFF0, 16'h0010, 2);
    wait_done("t4a");
    start_run(16'h0000, 16'h0002, 18);
    wait_done("t4b");

    // Zero-length run: done with no AR
    av0 = av_cnt;
    start_run(16'h4000, 16'h0001, 0);
    @(negedge clk);
    check_eq("t5_done_lat", 32'(done), 1);
    @(negedge clk);
    check_eq("t5_done_drop", 32'(done), 0);
    check_eq("t5_no_arvalid", 32'(av_cnt - av0), 0);
    wait_done("t5");

    // enable while busy is ignored
    start_run(16'h5000, 16'h0020, 4);
    @(posedge clk); #1;
    check_eq("t5_busy_mid", 32'(busy), 1);
    cfg_base_addr = 16'h9999; cfg_num_txn = 8'd7; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    wait_done("t5b");

    // Fast returns to overlap AR handshakes with retires
    r_delay = 1;
    start_run(16'h6000, 16'h0040, 6);
    wait_done("t5c");
    check_eq("t5_sim_hs_retire_seen", 32'(sim_cnt > 0), 1);
    r_delay = 2;

`ifdef EASYAXI_MST_RD_ERRCNT_EN
    err_left = 3;
    start_run(16'h0A00, 16'h0004, 5);
    wait_done("t6e");
    check_eq("t6_err_cnt", 32'(err_cnt), 3);
    start_run(16'h0B00, 16'h0004, 2);
    wait_done("t6f");
    check_eq("t6_err_cnt_cleared", 32'(err_cnt), 0);
`endif

    // Reset in DRAIN with two outstanding
    r_allow = 0;
    start_run(16'h7000, 16'h0010, 2);
    for (int i = 0; i < 20 && !(ost_cnt == 2 && !arvalid && busy); i++) @(negedge clk);
    check_eq("t6_ost_before_reset", 32'(ost_cnt), 2);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t6_reset");
    r_pend.delete();
    r_allow = 1000000;
    @(posedge clk); #1 rst_n = 1'b1;
    check_eq("t6_ar_left", 32'(exp_addr.size()), 0);
    start_run(16'h8000, 16'h0008, 2);
    wait_done("t6r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
